// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: register word addresses, CTRL/STATUS bit positions and the
// capture state encoding shared by the PWM input-capture block and its driver.
package pwm_capture_pkg;

    // Register word addresses
    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_STATUS  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD  = 3'd2;
    localparam logic [2:0] ADDR_HIGH    = 3'd3;
    localparam logic [2:0] ADDR_TIMEOUT = 3'd4;

    // CTRL bits
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    // STATUS bits (0..2 are write-1-to-clear, 3 is the live input level)
    localparam int STAT_NEW_BIT     = 0;
    localparam int STAT_TIMEOUT_BIT = 1;
    localparam int STAT_OVERRUN_BIT = 2;
    localparam int STAT_LEVEL_BIT   = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } cap_state_e;

endpackage

// File: rtl/pwm_capture_core.sv
// pwm_capture_core: measurement engine of the PWM input-capture block.
// Synchronizes the external PWM input, detects rising edges, and counts the
// period and high time of each complete cycle in clk cycles.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   pwm_input       - external asynchronous PWM signal
//   en              - capture enable (0 forces IDLE)
//   timeout_limit   - missing-edge limit in cycles, 0 disables
//   period, high    - last captured result (saturated at all-ones)
//   level           - synchronized input level
//   cap             - one-cycle pulse: a result is being captured this cycle
//   tmo             - one-cycle pulse: timeout detected this cycle
module pwm_capture_core
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pwm_input,
    input  logic              en,
    input  logic [DATA_W-1:0] timeout_limit,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  high,
    output logic              level,
    output logic              cap,
    output logic              tmo
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;
    logic                   tmo_hit;
    cap_state_e             state_q, state_d;
    logic [CNT_W-1:0]       per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0]       hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [CNT_W-1:0]       high_q, high_d;

    // Increment that sticks at all-ones so an out-of-range measurement stays visible.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != {CNT_W{1'b1}}))
            return v + CNT_ONE;
        return v;
    endfunction

    // Synchronizer chain plus one extra flop for edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_input};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level   = sync_q[SYNC_STAGES-1];
    assign rise    = level & ~prev_q;
    // Compares against the limit currently held, so a same-cycle write only affects later cycles.
    assign tmo_hit = (timeout_limit != '0) && (DATA_W'(per_cnt_q) == timeout_limit);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_ARM;
                ST_ARM:     if (rise) state_d = ST_MEASURE;
                ST_MEASURE: if (!rise && tmo_hit) state_d = ST_ARM;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Output / datapath logic
    always_comb begin
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        period_d  = period_q;
        high_d    = high_q;
        cap       = 1'b0;
        tmo       = 1'b0;
        case (state_q)
            ST_ARM: begin
                // The first edge only starts a measurement; it produces no result.
                per_cnt_d = (en && rise) ? CNT_ONE : '0;
                hi_cnt_d  = (en && rise) ? CNT_ONE : '0;
            end
            ST_MEASURE: begin
                if (!en) begin
                    per_cnt_d = '0;
                    hi_cnt_d  = '0;
                end else if (rise) begin
                    period_d  = per_cnt_q;
                    high_d    = hi_cnt_q;
                    cap       = 1'b1;
                    per_cnt_d = CNT_ONE;
                    hi_cnt_d  = CNT_ONE;
                end else if (tmo_hit) begin
                    tmo       = 1'b1;
                    per_cnt_d = '0;
                    hi_cnt_d  = '0;
                end else begin
                    per_cnt_d = sat_inc(per_cnt_q, 1'b1);
                    hi_cnt_d  = sat_inc(hi_cnt_q, level);
                end
            end
            default: begin
                per_cnt_d = '0;
                hi_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
        end else begin
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
        end
    end

    assign period = period_q;
    assign high   = high_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: PWM input-capture peripheral on the native CPU bus.
// Measures period and high time of an external PWM signal, flags missing
// edges (timeout) and unread results (overrun), and drives a level interrupt.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   pwm_input             - external asynchronous PWM signal
//   valid/address/wdata/wstrb - bus request (wstrb all-zero = read)
//   rdata/ready           - registered read data and one-cycle acknowledge
//   irq                   - registered level interrupt
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pwm_input,
    input  logic                valid,
    input  logic [2:0]          address,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic                irq
);

    logic [CNT_W-1:0]  period, high;
    logic              level, cap, tmo;

    logic [1:0]        ctrl_q, ctrl_d;
    logic              new_q, new_d;
    logic              timeout_q, timeout_d;
    logic              overrun_q, overrun_d;
    logic [DATA_W-1:0] timeout_lim_q, timeout_lim_d;
    logic [CNT_W-1:0]  high_hold_q, high_hold_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q;
    logic              irq_q;

    logic              accept, is_wr, is_rd;
    logic [DATA_W-1:0] wmask, wbits;
    logic [2:0]        clr;

    pwm_capture_core #(
        .CNT_W       (CNT_W),
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_core (
        .clk           (clk),
        .reset         (reset),
        .pwm_input     (pwm_input),
        .en            (ctrl_q[CTRL_EN_BIT]),
        .timeout_limit (timeout_lim_q),
        .period        (period),
        .high          (high),
        .level         (level),
        .cap           (cap),
        .tmo           (tmo)
    );

    // A request held across its own ready cycle is not accepted a second time.
    assign accept = valid & ~ready_q;
    assign is_wr  = accept & (|wstrb);
    assign is_rd  = accept & ~(|wstrb);

    always_comb begin
        wmask = '0;
        for (int b = 0; b < DATA_W/8; b++)
            wmask[8*b +: 8] = {8{wstrb[b]}};
    end
    assign wbits = wdata & wmask;

    always_comb begin
        ctrl_d        = ctrl_q;
        timeout_lim_d = timeout_lim_q;
        high_hold_d   = high_hold_q;
        rdata_d       = '0;
        clr           = '0;

        if (is_wr) begin
            case (address)
                ADDR_CTRL:    ctrl_d        = (ctrl_q & ~wmask[1:0]) | wbits[1:0];
                ADDR_STATUS:  clr           = wbits[2:0];
                ADDR_TIMEOUT: timeout_lim_d = (timeout_lim_q & ~wmask) | wbits;
                default:      ;
            endcase
        end

        if (is_rd) begin
            case (address)
                ADDR_CTRL:    rdata_d = DATA_W'(ctrl_q);
                ADDR_STATUS:  rdata_d = DATA_W'({level, overrun_q, timeout_q, new_q});
                ADDR_PERIOD: begin
                    // Registered results, so a same-cycle capture cannot tear the pair.
                    rdata_d     = DATA_W'(period);
                    high_hold_d = high;
                end
                ADDR_HIGH:    rdata_d = DATA_W'(high_hold_q);
                ADDR_TIMEOUT: rdata_d = timeout_lim_q;
                default:      rdata_d = '0;
            endcase
        end

        // Hardware sets are OR-ed in after the W1C clear so that a same-cycle set wins.
        new_d     = (new_q     & ~clr[STAT_NEW_BIT])     | cap;
        timeout_d = (timeout_q & ~clr[STAT_TIMEOUT_BIT]) | tmo;
        overrun_d = (overrun_q & ~clr[STAT_OVERRUN_BIT]) | (cap & new_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q        <= '0;
            new_q         <= 1'b0;
            timeout_q     <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_lim_q <= '0;
            high_hold_q   <= '0;
            rdata_q       <= '0;
            ready_q       <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            ctrl_q        <= ctrl_d;
            new_q         <= new_d;
            timeout_q     <= timeout_d;
            overrun_q     <= overrun_d;
            timeout_lim_q <= timeout_lim_d;
            high_hold_q   <= high_hold_d;
            rdata_q       <= rdata_d;
            ready_q       <= accept;
            irq_q         <= ctrl_q[CTRL_IRQ_EN_BIT] & (new_q | timeout_q);
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: self-checking bench for pwm_capture. Two instances share the
// bus and input: dut_a with 32-bit counters, dut_b with 8-bit counters for
// saturation. Register access is table-driven; capture behaviour is covered by
// hand-written sequences.
module tb_pwm_capture;

    localparam logic [2:0] A_CTRL    = 3'd0;
    localparam logic [2:0] A_STATUS  = 3'd1;
    localparam logic [2:0] A_PERIOD  = 3'd2;
    localparam logic [2:0] A_HIGH    = 3'd3;
    localparam logic [2:0] A_TIMEOUT = 3'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic        pwm_input;
    logic        valid;
    logic [2:0]  address;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata_a, rdata_b;
    logic        ready_a, ready_b, irq_a, irq_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // PWM generator controls
    int gen_period = 100;
    int gen_high   = 25;
    bit gen_on     = 1'b0;
    bit gen_idle   = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pwm_capture #(.CNT_W(32), .DATA_W(32), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .reset(reset), .pwm_input(pwm_input), .valid(valid),
        .address(address), .wdata(wdata), .wstrb(wstrb),
        .rdata(rdata_a), .ready(ready_a), .irq(irq_a)
    );

    pwm_capture #(.CNT_W(8), .DATA_W(32), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .reset(reset), .pwm_input(pwm_input), .valid(valid),
        .address(address), .wdata(wdata), .wstrb(wstrb),
        .rdata(rdata_b), .ready(ready_b), .irq(irq_b)
    );

    initial begin
        int phase;
        phase = 0;
        pwm_input = 1'b0;
        forever begin
            @(negedge clk);
            if (gen_on) begin
                pwm_input = (phase < gen_high);
                phase = (phase + 1 >= gen_period) ? 0 : phase + 1;
            end else begin
                pwm_input = gen_idle;
                phase = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus(input logic wr, input logic [2:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] ra, output logic [31:0] rb);
        int n;
        @(negedge clk);
        valid = 1'b1; address = a; wdata = d; wstrb = wr ? s : 4'h0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready_a && n < 8);
        if (!ready_a) begin
            checks++; failures++;
            $display("FAIL bus_ready_timeout: no ready for address %0d", a);
        end
        ra = rdata_a;
        rb = rdata_b;
        valid = 1'b0; wstrb = 4'h0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] ra, rb;
        bus(1'b1, a, d, 4'hF, ra, rb);
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] ra, output logic [31:0] rb);
        bus(1'b0, a, 32'h0, 4'h0, ra, rb);
    endtask

    task automatic wait_irq(input logic lvl, input int budget, input string name, output int at);
        int n;
        n = 0;
        while (irq_a !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (irq_a !== lvl) begin
            checks++; failures++;
            $display("FAIL %s: irq stayed %b, wanted %b within %0d cycles", name, irq_a, lvl, budget);
        end
        at = cyc;
    endtask

    typedef struct packed {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[20];

    initial begin
        logic [31:0] ra, rb;
        int t0, t1;

        vecs[0]  = '{1'b0, A_CTRL,    32'h0,        4'h0, 32'h0};
        vecs[1]  = '{1'b0, A_STATUS,  32'h0,        4'h0, 32'h0};
        vecs[2]  = '{1'b0, A_PERIOD,  32'h0,        4'h0, 32'h0};
        vecs[3]  = '{1'b0, A_HIGH,    32'h0,        4'h0, 32'h0};
        vecs[4]  = '{1'b0, A_TIMEOUT, 32'h0,        4'h0, 32'h0};
        vecs[5]  = '{1'b1, A_TIMEOUT, 32'hAABBCCDD, 4'h5, 32'h0};
        vecs[6]  = '{1'b0, A_TIMEOUT, 32'h0,        4'h0, 32'h00BB00DD};
        vecs[7]  = '{1'b1, A_TIMEOUT, 32'h12345678, 4'hF, 32'h0};
        vecs[8]  = '{1'b0, A_TIMEOUT, 32'h0,        4'h0, 32'h12345678};
        vecs[9]  = '{1'b1, A_CTRL,    32'hFFFFFFFF, 4'hF, 32'h0};
        vecs[10] = '{1'b0, A_CTRL,    32'h0,        4'h0, 32'h00000003};
        vecs[11] = '{1'b1, 3'd6,      32'hFFFFFFFF, 4'hF, 32'h0};
        vecs[12] = '{1'b0, 3'd6,      32'h0,        4'h0, 32'h0};
        vecs[13] = '{1'b0, 3'd7,      32'h0,        4'h0, 32'h0};
        vecs[14] = '{1'b1, A_STATUS,  32'h0000000F, 4'hF, 32'h0};
        vecs[15] = '{1'b0, A_STATUS,  32'h0,        4'h0, 32'h0};
        vecs[16] = '{1'b1, A_CTRL,    32'h0,        4'hF, 32'h0};
        vecs[17] = '{1'b0, A_CTRL,    32'h0,        4'h0, 32'h0};
        vecs[18] = '{1'b1, A_TIMEOUT, 32'h0,        4'hF, 32'h0};
        vecs[19] = '{1'b0, A_TIMEOUT, 32'h0,        4'h0, 32'h0};

        reset = 1'b1; valid = 1'b0; address = '0; wdata = '0; wstrb = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_rdata", rdata_a, 32'h0);
        check("reset_ready", {31'b0, ready_a}, 32'h0);
        check("reset_irq", {31'b0, irq_a}, 32'h0);

        // Register access table
        for (int i = 0; i < 20; i++) begin
            bus(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb, ra, rb);
            if (!vecs[i].wr)
                check($sformatf("vec%0d_rdata", i), ra, vecs[i].exp);
        end

        // Held request gets exactly one ready pulse per acceptance
        @(negedge clk);
        valid = 1'b1; address = A_CTRL; wstrb = 4'h0;
        @(negedge clk);
        check("ready_first", {31'b0, ready_a}, 32'h1);
        @(negedge clk);
        check("ready_not_back_to_back", {31'b0, ready_a}, 32'h0);
        valid = 1'b0;
        @(negedge clk);

        // Steady PWM 100/25
        wr(A_CTRL, 32'h3);
        gen_period = 100; gen_high = 25; gen_on = 1'b1;
        wait_irq(1'b1, 400, "steady_irq", t0);
        rd(A_PERIOD, ra, rb);  check("steady_period", ra, 32'd100);
        rd(A_HIGH, ra, rb);    check("steady_high", ra, 32'd25);
        rd(A_STATUS, ra, rb);  check("steady_status", ra & 32'h7, 32'h1);
        check("steady_irq_level", {31'b0, irq_a}, 32'h1);
        wr(A_STATUS, 32'h1);
        @(negedge clk);
        check("irq_after_w1c", {31'b0, irq_a}, 32'h0);

        // Overrun: two captures without clearing new
        repeat (210) @(negedge clk);
        rd(A_STATUS, ra, rb);  check("overrun_status", ra & 32'h7, 32'h5);

        // Coherent PERIOD/HIGH pair across later captures
        gen_period = 40; gen_high = 10;
        repeat (130) @(negedge clk);
        wr(A_STATUS, 32'h7);
        wait_irq(1'b0, 10, "coh_irq_low", t0);
        wait_irq(1'b1, 100, "coh_irq_high", t0);
        rd(A_PERIOD, ra, rb);  check("coh_period", ra, 32'd40);
        gen_period = 60; gen_high = 30;
        repeat (200) @(negedge clk);
        rd(A_HIGH, ra, rb);    check("coh_high_held", ra, 32'd10);
        check("coh_high_held_b", rb, 32'd10);
        rd(A_PERIOD, ra, rb);  check("coh_period2", ra, 32'd60);
        rd(A_HIGH, ra, rb);    check("coh_high2", ra, 32'd30);

        // Timeout 500 after the input stops low
        wr(A_TIMEOUT, 32'd500);
        wr(A_STATUS, 32'h7);
        wait_irq(1'b0, 10, "tmo_irq_low", t0);
        wait_irq(1'b1, 100, "tmo_capture", t0);
        gen_idle = 1'b0; gen_on = 1'b0;
        wr(A_STATUS, 32'h1);
        wait_irq(1'b0, 10, "tmo_irq_low2", t1);
        wait_irq(1'b1, 700, "tmo_fire", t1);
        check("timeout_cycles", t1 - t0, 32'd500);
        rd(A_STATUS, ra, rb);  check("timeout_status", ra & 32'h7, 32'h2);
        rd(A_PERIOD, ra, rb);  check("timeout_period_kept", ra, 32'd60);
        rd(A_HIGH, ra, rb);    check("timeout_high_kept", ra, 32'd30);

        // Restart: first edge re-arms only, second edge captures
        wr(A_STATUS, 32'h2);
        wait_irq(1'b0, 10, "restart_irq_low", t0);
        gen_period = 50; gen_high = 20; gen_on = 1'b1;
        repeat (40) @(negedge clk);
        rd(A_STATUS, ra, rb);  check("restart_no_result", ra & 32'h1, 32'h0);
        wait_irq(1'b1, 100, "restart_capture", t0);
        rd(A_PERIOD, ra, rb);  check("restart_period", ra, 32'd50);
        rd(A_HIGH, ra, rb);    check("restart_high", ra, 32'd20);

        // Saturation (dut_b has 8-bit counters)
        wr(A_TIMEOUT, 32'd0);
        gen_period = 300; gen_high = 280;
        repeat (700) @(negedge clk);
        rd(A_PERIOD, ra, rb);
        check("sat_period_a", ra, 32'd300);
        check("sat_period_b", rb, 32'd255);
        rd(A_HIGH, ra, rb);
        check("sat_high_a", ra, 32'd280);
        check("sat_high_b", rb, 32'd255);

        // Disable mid-period: no further captures, results retained
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'h7);
        gen_period = 100; gen_high = 25;
        repeat (300) @(negedge clk);
        rd(A_STATUS, ra, rb);  check("dis_status", ra & 32'h7, 32'h0);
        rd(A_PERIOD, ra, rb);  check("dis_period", ra, 32'd300);
        check("dis_period_b", rb, 32'd255);
        rd(A_HIGH, ra, rb);    check("dis_high", ra, 32'd280);

        // Level bit follows the synchronized input
        gen_on = 1'b0; gen_idle = 1'b1;
        repeat (6) @(negedge clk);
        rd(A_STATUS, ra, rb);  check("level_high", ra, 32'h8);
        gen_idle = 1'b0;
        repeat (6) @(negedge clk);
        rd(A_STATUS, ra, rb);  check("level_low", ra, 32'h0);

        // Reset in the middle of a measurement
        wr(A_TIMEOUT, 32'd1000);
        wr(A_CTRL, 32'h3);
        gen_on = 1'b1;
        wait_irq(1'b1, 400, "rst_pre_capture", t0);
        @(negedge clk);
        valid = 1'b1; address = A_PERIOD; wstrb = 4'h0;
        @(negedge clk);
        check("rst_pre_rdata", rdata_a, 32'd100);
        #2;
        reset = 1'b1;
        valid = 1'b0;
        #1;
        check("rst_async_rdata", rdata_a, 32'h0);
        check("rst_async_ready", {31'b0, ready_a}, 32'h0);
        check("rst_async_irq", {31'b0, irq_a}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rd(A_CTRL, ra, rb);    check("rst_ctrl", ra, 32'h0);
        rd(A_STATUS, ra, rb);  check("rst_status", ra & 32'h7, 32'h0);
        rd(A_PERIOD, ra, rb);  check("rst_period", ra, 32'h0);
        rd(A_HIGH, ra, rb);    check("rst_high", ra, 32'h0);
        rd(A_TIMEOUT, ra, rb); check("rst_timeout", ra, 32'h0);
        gen_on = 1'b0;
        wr(A_CTRL, 32'h3);
        gen_on = 1'b1;
        repeat (60) @(negedge clk);
        check("rst_first_edge_no_irq", {31'b0, irq_a}, 32'h0);
        rd(A_STATUS, ra, rb);  check("rst_first_edge_no_new", ra & 32'h1, 32'h0);
        wait_irq(1'b1, 200, "rst_second_edge", t0);
        rd(A_PERIOD, ra, rb);  check("rst_period_after", ra, 32'd100);
        rd(A_HIGH, ra, rb);    check("rst_high_after", ra, 32'd25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
